video_timing_rx: RTL and testbench
==================================

Name: video_timing_rx

Overview:
Receive-side counterpart to the 480p DVI/parallel video output path. The block samples hsync/vsync/de and 12-bit RGB on the pixel clock. It recovers per-pixel screen coordinates, measures the active line width and frame height, and declares lock after a run of frames that match the expected geometry. It sits on the capture/loopback side of the board so that the game's video output can be checked in hardware and on the bench.

Parameters:
CORDW, 10, width of coordinate and measurement counters in bits
H_RES, 640, expected active pixels per line
V_RES, 480, expected active lines per frame
LOCK_FRAMES, 2, consecutive good frames required to assert lock (range 1..15)
SYNC_NEG, 1, 1 = hsync/vsync active-low, 0 = active-high

Ports:
clk_i  input  1  pixel clock; the block's only clock
reset_i  input  1  asynchronous, active-high reset
hsync_i  input  1  horizontal sync, polarity set by SYNC_NEG
vsync_i  input  1  vertical sync, polarity set by SYNC_NEG
de_i  input  1  data enable, high during active pixels
rgb_i  input  12  {r[3:0], g[3:0], b[3:0]} pixel data
pix_valid_o  output  1  rgb_o/sx_o/sy_o hold an active pixel
sx_o  output  CORDW  recovered x coordinate of the current pixel
sy_o  output  CORDW  recovered y coordinate of the current pixel
rgb_o  output  12  pixel data aligned to sx_o/sy_o
frame_o  output  1  one-cycle pulse at each vsync leading edge
locked_o  output  1  geometry matches H_RES x V_RES for LOCK_FRAMES frames
width_o  output  CORDW  last measured active line width
height_o  output  CORDW  last measured active line count
err_o  output  1  one-cycle pulse when a frame fails the check while locked

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Reset clears every register.
  - All outputs are 0 during and after reset, FSM = SEARCH.
  - Reset mid-frame discards partial counts. The first frame boundary after reset is used only for alignment.
- Input stage: hsync_i, vsync_i, de_i and rgb_i are registered once. Sync signals are normalised internally to active-high using SYNC_NEG.
- Latency: pix_valid_o/sx_o/sy_o/rgb_o follow de_i/rgb_i by exactly 2 cycles. frame_o is 2 cycles after the vsync leading edge appears on vsync_i.
- x counter:
  - Cleared while de is low.
  - On each de-high cycle, sx_o = current count, then count increments.
  - Saturates at 2^CORDW-1 and marks the line bad.
- Line end (de falling edge):
  - width_o <= pixels seen in the line.
  - Line is bad if width != H_RES.
  - y counter increments, saturating at 2^CORDW-1.
- sy_o is the y count for the line in progress, starting at 0 on the first line after vsync.
- Frame boundary (vsync leading edge):
  - height_o <= y count.
  - frame_o pulses.
  - y counter clears.
  - The frame is good iff height == V_RES, no bad line occurred, and de was not high at the edge.
  - The per-frame bad flag then clears.
- de high on the cycle vsync asserts: the line in progress is truncated and counted, and the frame is marked bad.
- hsync is observed only for the bad-frame rule: de high while hsync is active marks the frame bad. It is not used for counting.
- FSM:
  - SEARCH: locked_o=0. First frame boundary -> CHECK with good_cnt=0. That frame is not evaluated.
  - CHECK: locked_o=0. At each boundary, a good frame increments good_cnt. When good_cnt reaches LOCK_FRAMES -> LOCKED. A bad frame sets good_cnt=0 and stays in CHECK.
  - LOCKED: locked_o=1. A good frame stays. A bad frame pulses err_o, drops to CHECK with good_cnt=0, and deasserts locked_o on the same edge.
- good_cnt is 4 bits. It saturates and never wraps.
- width_o/height_o update on every line end / frame boundary regardless of FSM state.

Test Plan:
- Reset: assert reset_i asynchronously mid-line -> all outputs 0 immediately. After release with no sync activity, locked_o stays 0 and frame_o never pulses.
- Nominal lock: drive 3 clean 640x480 frames with active-low syncs -> frame_o pulses 3 times, height_o=480, width_o=640. locked_o rises at the third vsync edge (first edge aligns, edges 2 and 3 are good). err_o stays 0.
- Coordinates: in a locked frame, the pixel at line 10, column 5 with rgb_i=12'hABC -> two cycles later pix_valid_o=1, sx_o=5, sy_o=10, rgb_o=12'hABC. pix_valid_o=0 in blanking.
- Short line while locked: one line with 639 de cycles -> width_o=639 after that line. At the next vsync edge, err_o pulses once and locked_o drops. Two further clean frames relock.
- Height mismatch: frames with 479 active lines -> height_o=479, locked_o never asserts. Restoring 480 lines gives lock after LOCK_FRAMES good frames.
- de overlapping vsync and saturation: de held high across the vsync leading edge -> that frame is bad with no lock increment. de held high for 1100 cycles -> sx_o saturates at 1023 and the line is flagged bad.

Source files
------------

// File: rtl/video_timing_rx.sv
// Video timing receiver: registers the incoming sync/de/rgb stream, recovers pixel
// coordinates, measures line width and frame height, and tracks geometry lock.
module video_timing_rx #(
    parameter int CORDW       = 10,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int LOCK_FRAMES = 2,
    parameter bit SYNC_NEG    = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             de_i,
    input  logic [11:0]      rgb_i,
    output logic             pix_valid_o,
    output logic [CORDW-1:0] sx_o,
    output logic [CORDW-1:0] sy_o,
    output logic [11:0]      rgb_o,
    output logic             frame_o,
    output logic             locked_o,
    output logic [CORDW-1:0] width_o,
    output logic [CORDW-1:0] height_o,
    output logic             err_o
);
    localparam logic [CORDW-1:0] CMAX   = '1;
    localparam logic [CORDW-1:0] H_EXP  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_EXP  = CORDW'(V_RES);
    localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [11:0]      rgb_in_q, rgb_in_d;
    logic             de_prev_q, de_prev_d, vs_prev_q, vs_prev_d;
    logic [CORDW-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic             sat_q, sat_d, frame_bad_q, frame_bad_d;
    logic             pix_valid_q, pix_valid_d;
    logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [11:0]      rgb_q, rgb_d;
    logic [CORDW-1:0] width_q, width_d, height_q, height_d;
    logic             frame_q, frame_d, locked_q, locked_d, err_q, err_d;
    state_t           state_q, state_d;
    logic [3:0]       good_cnt_q, good_cnt_d;

    logic [CORDW-1:0] x_inc, y_inc, y_after, line_width;
    logic [3:0]       cnt_inc;
    logic             vs_rise, trunc, line_end, line_bad, hs_bad, frame_good;

    always_comb begin
        hs_d      = hsync_i ^ SYNC_NEG;
        vs_d      = vsync_i ^ SYNC_NEG;
        de_d      = de_i;
        rgb_in_d  = rgb_i;
        de_prev_d = de_q;
        vs_prev_d = vs_q;

        x_inc   = (x_cnt_q == CMAX) ? CMAX : x_cnt_q + 1'b1;
        y_inc   = (y_cnt_q == CMAX) ? CMAX : y_cnt_q + 1'b1;
        cnt_inc = (good_cnt_q == 4'hF) ? 4'hF : good_cnt_q + 4'd1;

        vs_rise = vs_q & ~vs_prev_q;
        // de still high on the vsync edge closes the line early and counts it
        trunc      = vs_rise & de_q;
        line_end   = (de_prev_q & ~de_q) | trunc;
        line_width = de_q ? x_inc : x_cnt_q;
        line_bad   = (line_width != H_EXP) | sat_q | (de_q & (x_cnt_q == CMAX));
        hs_bad     = de_q & hs_q;
        y_after    = line_end ? y_inc : y_cnt_q;

        x_cnt_d = (de_q && !trunc) ? x_inc : '0;
        sat_d   = (de_q && !trunc) ? (sat_q | (x_cnt_q == CMAX)) : 1'b0;
        y_cnt_d = vs_rise ? '0 : y_after;

        width_d  = line_end ? line_width : width_q;
        height_d = vs_rise ? y_after : height_q;

        frame_bad_d = vs_rise ? 1'b0 : (frame_bad_q | hs_bad | (line_end & line_bad));
        frame_good  = (y_after == V_EXP) & ~frame_bad_q & ~hs_bad
                      & ~(line_end & line_bad) & ~de_q;

        pix_valid_d = de_q;
        sx_d        = de_q ? x_cnt_q : '0;
        sy_d        = de_q ? y_cnt_q : '0;
        rgb_d       = de_q ? rgb_in_q : 12'h000;

        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        locked_d   = locked_q;
        err_d      = 1'b0;
        frame_d    = vs_rise;
        if (vs_rise) begin
            case (state_q)
                SEARCH: begin
                    state_d    = CHECK;
                    good_cnt_d = 4'd0;
                    locked_d   = 1'b0;
                end
                CHECK: begin
                    if (frame_good) begin
                        good_cnt_d = cnt_inc;
                        if (cnt_inc >= LOCK_N) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        good_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (frame_good) begin
                        good_cnt_d = cnt_inc;
                    end else begin
                        err_d      = 1'b1;
                        state_d    = CHECK;
                        good_cnt_d = 4'd0;
                        locked_d   = 1'b0;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    good_cnt_d = 4'd0;
                    locked_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            rgb_in_q    <= 12'h000;
            de_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            sat_q       <= 1'b0;
            frame_bad_q <= 1'b0;
            pix_valid_q <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            rgb_q       <= 12'h000;
            width_q     <= '0;
            height_q    <= '0;
            frame_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= SEARCH;
            good_cnt_q  <= 4'd0;
        end else begin
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            rgb_in_q    <= rgb_in_d;
            de_prev_q   <= de_prev_d;
            vs_prev_q   <= vs_prev_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            sat_q       <= sat_d;
            frame_bad_q <= frame_bad_d;
            pix_valid_q <= pix_valid_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            rgb_q       <= rgb_d;
            width_q     <= width_d;
            height_q    <= height_d;
            frame_q     <= frame_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
        end
    end

    assign pix_valid_o = pix_valid_q;
    assign sx_o        = sx_q;
    assign sy_o        = sy_q;
    assign rgb_o       = rgb_q;
    assign frame_o     = frame_q;
    assign locked_o    = locked_q;
    assign width_o     = width_q;
    assign height_o    = height_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_video_timing_rx.sv
// Randomised frame stream against a frame-level geometry/lock model, with a
// scoreboard monitor comparing pixels, line widths and frame events.
module tb_video_timing_rx;
    localparam int CORDW = 10;
    localparam int H_RES = 16;
    localparam int V_RES = 12;
    localparam int LOCK_FRAMES = 2;
    localparam bit SYNC_NEG = 1'b1;
    localparam int CMAX = (1 << CORDW) - 1;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic hsync_i = SYNC_NEG, vsync_i = SYNC_NEG, de_i = 1'b0;
    logic [11:0] rgb_i = 12'h000;
    logic pix_valid_o, frame_o, locked_o, err_o;
    logic [CORDW-1:0] sx_o, sy_o, width_o, height_o;
    logic [11:0] rgb_o;

    video_timing_rx #(.CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES),
                      .LOCK_FRAMES(LOCK_FRAMES), .SYNC_NEG(SYNC_NEG)) dut (
        .clk_i(clk), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .de_i(de_i), .rgb_i(rgb_i), .pix_valid_o(pix_valid_o), .sx_o(sx_o),
        .sy_o(sy_o), .rgb_o(rgb_o), .frame_o(frame_o), .locked_o(locked_o),
        .width_o(width_o), .height_o(height_o), .err_o(err_o));

    always #5 clk = ~clk;

    typedef struct { int h; bit lk; bit er; } frm_t;
    logic [31:0] pix_q[$];
    int          wid_q[$];
    frm_t        frm_q[$];

    int n_checks = 0, n_fail = 0;

    // frame-level reference state
    int m_lines = 0, m_run = 0;
    bit m_bad = 0, m_aligned = 0, m_locked = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int satc(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic drive(input bit hs, input bit vs, input bit de, input logic [11:0] rgb);
        @(negedge clk);
        hsync_i = hs ^ SYNC_NEG;
        vsync_i = vs ^ SYNC_NEG;
        de_i    = de;
        rgb_i   = rgb;
    endtask

    task automatic pixel(input int col, input bit hs, input bit vs);
        logic [11:0] c;
        c = (m_lines == 10 && col == 5) ? 12'hABC : 12'($urandom);
        drive(hs, vs, 1'b1, c);
        pix_q.push_back({10'(satc(col)), 10'(satc(m_lines)), c});
    endtask

    task automatic end_line(input int w);
        wid_q.push_back(satc(w));
        if (w != H_RES) m_bad = 1'b1;
        m_lines++;
    endtask

    task automatic frame_edge(input bit de_now);
        int h;
        bit good, er;
        h    = satc(m_lines + (de_now ? 1 : 0));
        good = (h == V_RES) && !m_bad && !de_now;
        er   = 1'b0;
        if (!m_aligned) begin
            m_aligned = 1'b1;
            m_run = 0;
        end else if (good) begin
            m_run = (m_run < 15) ? m_run + 1 : 15;
            if (m_run >= LOCK_FRAMES) m_locked = 1'b1;
        end else begin
            er = m_locked;
            m_locked = 1'b0;
            m_run = 0;
        end
        frm_q.push_back('{h: h, lk: m_locked, er: er});
        m_lines = 0;
        m_bad = 1'b0;
    endtask

    task automatic send_line(input int w, input bit hs_ovl);
        for (int c = 0; c < w; c++) pixel(c, hs_ovl && c == 0, 1'b0);
        if (hs_ovl) m_bad = 1'b1;
        end_line(w);
        repeat ($urandom_range(2, 4)) drive(0, 0, 0, 12'h000);
        repeat (2) drive(1, 0, 0, 12'h000);
        repeat (2) drive(0, 0, 0, 12'h000);
    endtask

    task automatic vsync_gap();
        drive(0, 1, 0, 12'h000);
        frame_edge(1'b0);
        repeat (2) drive(0, 1, 0, 12'h000);
        repeat (3) drive(0, 0, 0, 12'h000);
    endtask

    task automatic send_frame(input int nl, input int bad_idx, input int bad_w, input int hs_idx);
        vsync_gap();
        for (int i = 0; i < nl; i++) send_line((i == bad_idx) ? bad_w : H_RES, i == hs_idx);
    endtask

    // de stays high through the vsync edge, then continues k pixels into the new frame
    task automatic across(input int a, input int k);
        for (int i = 0; i < a; i++) pixel(i, 1'b0, 1'b0);
        pixel(a, 1'b0, 1'b1);
        frame_edge(1'b1);
        for (int i = 0; i < k; i++) pixel(i, 1'b0, 1'b1);
        end_line(k);
        repeat (2) drive(0, 1, 0, 12'h000);
        repeat (3) drive(0, 0, 0, 12'h000);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'(|{pix_valid_o, sx_o, sy_o, rgb_o, frame_o, locked_o,
                          width_o, height_o, err_o}), 32'd0);
    endtask

    // monitor: pops expectations whenever the DUT presents an event
    initial begin
        bit prev_pv, mon_locked;
        logic [31:0] e;
        int w;
        frm_t f;
        prev_pv = 1'b0;
        mon_locked = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                prev_pv = 1'b0;
                mon_locked = 1'b0;
            end else begin
                if (pix_valid_o) begin
                    if (pix_q.size() == 0) check("pix_unexpected", 32'd1, 32'd0);
                    else begin
                        e = pix_q.pop_front();
                        check("pixel_sx_sy_rgb", {sx_o, sy_o, rgb_o}, e);
                    end
                end
                if (!pix_valid_o && prev_pv) begin
                    if (wid_q.size() == 0) check("width_unexpected", 32'd1, 32'd0);
                    else begin
                        w = wid_q.pop_front();
                        check("width", 32'(width_o), 32'(w));
                    end
                end
                if (frame_o) begin
                    if (frm_q.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
                    else begin
                        f = frm_q.pop_front();
                        check("frame_height", 32'(height_o), 32'(f.h));
                        check("frame_locked", 32'(locked_o), 32'(f.lk));
                        check("frame_err", 32'(err_o), 32'(f.er));
                        mon_locked = f.lk;
                    end
                end else begin
                    check("err_outside_frame", 32'(err_o), 32'd0);
                    check("locked_steady", 32'(locked_o), 32'(mon_locked));
                end
                prev_pv = pix_valid_o;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset_outputs");
        @(negedge clk);
        reset_i = 1'b0;
        repeat (40) drive(0, 0, 0, 12'h000);
        check("idle_no_lock", 32'(locked_o), 32'd0);

        // nominal lock, coordinates, short line, relock
        repeat (3) send_frame(V_RES, -1, 0, -1);
        send_frame(V_RES, 3, H_RES - 1, -1);
        repeat (3) send_frame(V_RES, -1, 0, -1);

        // height mismatch then recovery
        repeat (3) send_frame(V_RES - 1, -1, 0, -1);
        repeat (3) send_frame(V_RES, -1, 0, -1);

        // de across vsync
        vsync_gap();
        for (int i = 0; i < V_RES - 1; i++) send_line(H_RES, 1'b0);
        across(5, 7);
        for (int i = 0; i < V_RES - 1; i++) send_line(H_RES, 1'b0);
        repeat (2) send_frame(V_RES, -1, 0, -1);

        // x saturation
        vsync_gap();
        send_line(1100, 1'b0);
        for (int i = 0; i < V_RES - 1; i++) send_line(H_RES, 1'b0);
        repeat (3) send_frame(V_RES, -1, 0, -1);

        // asynchronous reset in the middle of a line while locked
        vsync_gap();
        for (int i = 0; i < 3; i++) send_line(H_RES, 1'b0);
        for (int c = 0; c < 6; c++) pixel(c, 1'b0, 1'b0);
        #2 reset_i = 1'b1;
        #1 check_all_zero("async_reset_midline");
        de_i = 1'b0; hsync_i = SYNC_NEG; vsync_i = SYNC_NEG;
        pix_q.delete(); wid_q.delete(); frm_q.delete();
        m_lines = 0; m_run = 0; m_bad = 0; m_aligned = 0; m_locked = 0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (30) drive(0, 0, 0, 12'h000);
        check("post_reset_no_lock", 32'(locked_o), 32'd0);

        // randomised frame stream with occasional faults
        for (int f = 0; f < 30; f++) begin
            int kind;
            kind = $urandom_range(0, 9);
            case (kind)
                6: send_frame(V_RES, $urandom_range(0, V_RES - 1),
                              $urandom_range(0, 1) ? H_RES + $urandom_range(1, 3)
                                                   : H_RES - $urandom_range(1, 3), -1);
                7: send_frame($urandom_range(0, 1) ? V_RES + 1 : V_RES - 1, -1, 0, -1);
                8: send_frame(V_RES, -1, 0, $urandom_range(0, V_RES - 1));
                default: send_frame(V_RES, -1, 0, -1);
            endcase
        end
        vsync_gap();
        repeat (6) drive(0, 0, 0, 12'h000);

        check("pix_queue_drained", 32'(pix_q.size()), 32'd0);
        check("width_queue_drained", 32'(wid_q.size()), 32'd0);
        check("frame_queue_drained", 32'(frm_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
